mmult_seq: RTL and testbench

- Sequencer for the GPU matrix-multiply unit.
- Drives the matrix address counter controls (cntld, cnten, maddw, mwidth), the register-bank read strobe and the multiply-accumulate enables for one vector-by-matrix-column operation.
- Arbitrates GPU writes of the matrix address register against a running operation.
- Signals completion back to the GPU pipeline.

---
 rtl/mmult_seq_if.sv | 34 +++
 rtl/mmult_seq.sv | 105 ++++++++++
 tb/tb_mmult_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mmult_seq_if.sv
// GPU <-> matrix-multiply sequencer signal bundle.
// master = GPU decode/pipeline side, slave = sequencer side.
interface mmult_seq_if #(
   parameter int CNT_W = 4
) ();
   logic             start;
   logic             mode_col;
   logic [CNT_W-1:0] width;
   logic             mtxa_wr;
   logic             hold;
   logic             cntld;
   logic             cnten;
   logic             maddw;
   logic [CNT_W-1:0] mwidth;
   logic             wr_stall;
   logic             mem_rd;
   logic             mac_clr;
   logic             mac_en;
   logic             res_wr;
   logic             busy;
   logic             done;

   modport master (
      output start, mode_col, width, mtxa_wr, hold,
      input  cntld, cnten, maddw, mwidth, wr_stall, mem_rd,
             mac_clr, mac_en, res_wr, busy, done
   );

   modport slave (
      input  start, mode_col, width, mtxa_wr, hold,
      output cntld, cnten, maddw, mwidth, wr_stall, mem_rd,
             mac_clr, mac_en, res_wr, busy, done
   );
endinterface

// File: rtl/mmult_seq.sv
// Sequencer for one vector-by-matrix-column multiply: steps the address counter,
// issues reads, gates the MAC and arbitrates matrix-address writes.
//
// state | meaning
// IDLE  | waiting for start; matrix address writes pass straight through
// RUN   | issuing one element per non-held cycle, rem_q elements left
// DRAIN | waiting PIPE_LAT cycles for the MAC pipeline to settle
module mmult_seq #(
   parameter int PIPE_LAT = 2,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        resetl,
   mmult_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] mwidth_q;
   logic [2:0]       drain_q;
   logic             maddw_q;
   logic             busy_q;
   logic             done_q;
   logic             res_wr_q;
   logic             mac_en_q;
   logic             mac_clr_q;
   logic             first_q;
   logic             issue;

   assign issue = (state_q == RUN) & ~bus.hold;

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         mwidth_q  <= '0;
         drain_q   <= '0;
         maddw_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         res_wr_q  <= 1'b0;
         mac_en_q  <= 1'b0;
         mac_clr_q <= 1'b0;
         first_q   <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         res_wr_q  <= 1'b0;
         mac_en_q  <= issue;
         mac_clr_q <= issue & first_q;
         if (issue) first_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  maddw_q  <= bus.mode_col;
                  mwidth_q <= bus.width;
                  rem_q    <= bus.width;
                  first_q  <= 1'b1;
                  // a zero-length op completes at once without touching the datapath
                  if (bus.width == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == 1) begin
                     state_q <= DRAIN;
                     drain_q <= 3'(PIPE_LAT);
                  end
               end
            end
            DRAIN: begin
               drain_q <= drain_q - 3'd1;
               if (drain_q == 3'd1) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  res_wr_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // the address register may only load when no operation is walking it
   assign bus.cntld    = bus.mtxa_wr & ~busy_q;
   assign bus.wr_stall = bus.mtxa_wr & busy_q;
   assign bus.cnten    = issue;
   assign bus.mem_rd   = issue;
   assign bus.maddw    = maddw_q;
   assign bus.mwidth   = mwidth_q;
   assign bus.mac_en   = mac_en_q;
   assign bus.mac_clr  = mac_clr_q;
   assign bus.res_wr   = res_wr_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_mmult_seq.sv
// Bench for mmult_seq: directed ops with per-cycle control checks plus a
// completion scoreboard (done timing, result write, per-op advance counts).
module tb_mmult_seq;

   logic clk = 1'b0;
   logic resetl;
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;

   mmult_seq_if #(.CNT_W(4)) bus ();

   mmult_seq #(.PIPE_LAT(2), .CNT_W(4)) dut (
      .clk    (clk),
      .resetl (resetl),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      bit         res;
      bit         maddw;
      logic [3:0] mwidth;
      int         n_en;
      int         n_mac;
      int         n_clr;
   } exp_t;

   exp_t sb[$];
   int   cnt_en = 0;
   int   cnt_mac = 0;
   int   cnt_clr = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // completion monitor
   always @(negedge clk) begin
      if (!resetl) begin
         cnt_en = 0; cnt_mac = 0; cnt_clr = 0;
      end else begin
         cnt_en  += int'(bus.cnten);
         cnt_mac += int'(bus.mac_en);
         cnt_clr += int'(bus.mac_clr);
         if (bus.done || bus.res_wr) begin
            chk("sb_has_entry_at_done", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("done_cycle", cyc, e.at);
               chk("done_flag", int'(bus.done), 1);
               chk("res_wr", int'(bus.res_wr), int'(e.res));
               chk("done_maddw", int'(bus.maddw), int'(e.maddw));
               chk("done_mwidth", int'(bus.mwidth), int'(e.mwidth));
               chk("op_cnten_count", cnt_en, e.n_en);
               chk("op_mac_en_count", cnt_mac, e.n_mac);
               chk("op_mac_clr_count", cnt_clr, e.n_clr);
            end
            cnt_en = 0; cnt_mac = 0; cnt_clr = 0;
         end
      end
   end

   task automatic idle_inputs();
      bus.start = 1'b0; bus.mode_col = 1'b0; bus.width = 4'd0;
      bus.mtxa_wr = 1'b0; bus.hold = 1'b0;
   endtask

   // Entered and left at posedge+1. Masks are indexed by cycle relative to start.
   task automatic op(input string nm, input bit mode, input logic [3:0] w,
                     input int done_at, input int n_en, input int ncyc,
                     input logic [15:0] start_m, input logic [15:0] hold_m,
                     input logic [15:0] wr_m, input logic [15:0] en_m,
                     input logic [15:0] mac_m, input logic [15:0] clr_m,
                     input logic [15:0] busy_m, input logic [15:0] cntld_m,
                     input logic [15:0] stall_m);
      exp_t       e;
      logic [6:0] got, want;
      e.at = cyc + done_at; e.res = (w != 4'd0); e.maddw = mode; e.mwidth = w;
      e.n_en = n_en; e.n_mac = n_en; e.n_clr = (n_en > 0) ? 1 : 0;
      sb.push_back(e);
      for (int k = 0; k < ncyc; k++) begin
         bus.start    = start_m[k];
         bus.mode_col = (k == 0) ? mode : ~mode;
         bus.width    = (k == 0) ? w : ~w;
         bus.hold     = hold_m[k];
         bus.mtxa_wr  = wr_m[k];
         @(negedge clk);
         got  = {bus.busy, bus.cnten, bus.mem_rd, bus.mac_en, bus.mac_clr,
                 bus.cntld, bus.wr_stall};
         want = {busy_m[k], en_m[k], en_m[k], mac_m[k], clr_m[k],
                 cntld_m[k], stall_m[k]};
         chk($sformatf("%s_c%0d_ctl", nm, k), int'(got), int'(want));
         if (k >= 1)
            chk($sformatf("%s_c%0d_latch", nm, k),
                int'({bus.maddw, bus.mwidth}), int'({mode, w}));
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   initial begin
      logic [15:0] outs;
      resetl = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 resetl = 1'b1;

      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         outs = {bus.cntld, bus.cnten, bus.maddw, bus.mwidth, bus.wr_stall,
                 bus.mem_rd, bus.mac_clr, bus.mac_en, bus.res_wr, bus.busy,
                 bus.done, 2'b00};
         chk($sformatf("reset_idle_c%0d", k), int'(outs), 0);
         @(posedge clk); #1;
      end

      // row op, W=4: cnten 1-4, mac 2-5, clr 2, busy 1-6, done 7
      op("row4", 1'b0, 4'd4, 7, 4, 9, 16'h0001, 16'h0000, 16'h0000,
         16'h001E, 16'h003C, 16'h0004, 16'h007E, 16'h0000, 16'h0000);

      // column op, W=3, hold 2-3: cnten 1,4,5, mac 2,5,6, busy 1-7, done 8
      op("col3h", 1'b1, 4'd3, 8, 3, 10, 16'h0001, 16'h000C, 16'h0000,
         16'h0032, 16'h0064, 16'h0004, 16'h00FE, 16'h0000, 16'h0000);

      // W=5 with mtxa_wr from cycle 2 and a stray start at 3: stall 2-7, cntld 8
      op("arb5", 1'b0, 4'd5, 8, 5, 11, 16'h0009, 16'h0000, 16'h01FC,
         16'h003E, 16'h007C, 16'h0004, 16'h00FE, 16'h0100, 16'h00FC);

      // load and start together: cntld at 0, cnten 1-2, busy 1-4, done 5
      op("ldst2", 1'b1, 4'd2, 5, 2, 7, 16'h0001, 16'h0000, 16'h0001,
         16'h0006, 16'h000C, 16'h0004, 16'h001E, 16'h0001, 16'h0000);

      // zero-width: done at 1, nothing else
      op("w0", 1'b1, 4'd0, 1, 0, 3, 16'h0001, 16'h0000, 16'h0000,
         16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

      // reset in the middle of a W=15 run, no completion expected
      bus.start = 1'b1; bus.mode_col = 1'b1; bus.width = 4'd15;
      @(posedge clk); #1;
      idle_inputs();
      repeat (5) @(posedge clk);
      #1;
      chk("prereset_busy", int'(bus.busy), 1);
      chk("prereset_mac_en", int'(bus.mac_en), 1);
      resetl = 1'b0;
      #1;
      chk("midreset_ctl", int'({bus.busy, bus.cnten, bus.mac_en, bus.mem_rd}), 0);
      @(negedge clk);
      chk("midreset_regs", int'({bus.done, bus.res_wr, bus.maddw, bus.mwidth}), 0);
      repeat (2) @(posedge clk);
      #1 resetl = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("postreset_quiet", int'({bus.busy, bus.cnten, bus.done, bus.res_wr}), 0);
      end
      @(posedge clk); #1;

      op("row4b", 1'b0, 4'd4, 7, 4, 9, 16'h0001, 16'h0000, 16'h0000,
         16'h001E, 16'h003C, 16'h0004, 16'h007E, 16'h0000, 16'h0000);

      repeat (3) @(posedge clk);
      chk("sb_empty_at_end", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
